// File: rtl/digota_gate_drv.sv
// DIGOTA gate driver: synchronised requests, two dead-time legs, fault flag.
// Optional glitch filter enabled by DIGOTA_GLITCH_FILTER_EN.
module digota_gate_drv #(
    parameter int DT_W     = 4,
    parameter int FILT_LEN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            opmos_req,
    input  logic            onmos_req,
    input  logic            cmpmos_req,
    input  logic            cmnmos_req,
    input  logic [DT_W-1:0] dt_sel,
    input  logic            fault_clr,
    output logic            opmos_g,
    output logic            onmos_g,
    output logic            cmpmos_g,
    output logic            cmnmos_g,
    output logic            busy,
    output logic            fault_sticky
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_PON  = 2'd1,
        S_NON  = 2'd2,
        S_DEAD = 2'd3
    } state_e;

    // Bit order {cmnmos, cmpmos, onmos, opmos}; OFF request is pmos=1, nmos=0.
    localparam logic [3:0] REQ_OFF = 4'b0101;

    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_range
        $error("FILT_LEN must be in 2..15");
    end

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] req;

    state_e          state_q [2];
    state_e          state_d [2];
    logic [DT_W-1:0] cnt_q   [2];
    logic [DT_W-1:0] cnt_d   [2];
    logic [1:0]      pg_d;
    logic [1:0]      ng_d;
    logic            busy_d;
    logic            conflict;
    logic            fault_d;
    logic [DT_W-1:0] dt_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= REQ_OFF;
            sync2_q <= REQ_OFF;
        end else begin
            sync1_q <= {cmnmos_req, cmpmos_req, onmos_req, opmos_req};
            sync2_q <= sync1_q;
        end
    end

`ifdef DIGOTA_GLITCH_FILTER_EN
    logic [3:0] filt_q;
    logic [3:0] fcnt_q [4];

    // A bit follows the synchroniser only after FILT_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= REQ_OFF;
            for (int b = 0; b < 4; b++) fcnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sync2_q[b] != filt_q[b]) begin
                    if (fcnt_q[b] == 4'(FILT_LEN - 1)) begin
                        filt_q[b] <= sync2_q[b];
                        fcnt_q[b] <= '0;
                    end else begin
                        fcnt_q[b] <= fcnt_q[b] + 4'd1;
                    end
                end else begin
                    fcnt_q[b] <= '0;
                end
            end
        end
    end

    assign req = filt_q;
`else
    assign req = sync2_q;
`endif

    assign dt_load = (dt_sel == '0) ? DT_W'(1) : dt_sel;

    always_comb begin
        conflict = 1'b0;
        busy_d   = 1'b0;
        for (int l = 0; l < 2; l++) begin
            logic   pr;
            logic   nr;
            state_e tgt;
            pr = req[2*l];
            nr = req[2*l+1];
            if (!pr && nr) conflict = 1'b1;
            if (!pr && !nr)     tgt = S_PON;
            else if (pr && nr)  tgt = S_NON;
            else                tgt = S_OFF;
            state_d[l] = state_q[l];
            cnt_d[l]   = cnt_q[l];
            unique case (state_q[l])
                S_OFF: state_d[l] = tgt;
                S_PON, S_NON: begin
                    if (tgt != state_q[l]) begin
                        state_d[l] = S_DEAD;
                        cnt_d[l]   = dt_load;
                    end
                end
                S_DEAD: begin
                    if (cnt_q[l] <= DT_W'(1)) begin
                        state_d[l] = tgt;
                        cnt_d[l]   = '0;
                    end else begin
                        cnt_d[l] = cnt_q[l] - DT_W'(1);
                    end
                end
                default: state_d[l] = S_OFF;
            endcase
            pg_d[l] = (state_d[l] != S_PON);
            ng_d[l] = (state_d[l] == S_NON);
            if (state_d[l] == S_DEAD) busy_d = 1'b1;
        end
        // A new conflict outranks a simultaneous clear.
        fault_d = conflict | (fault_sticky & ~fault_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                state_q[l] <= S_OFF;
                cnt_q[l]   <= '0;
            end
            opmos_g      <= 1'b1;
            onmos_g      <= 1'b0;
            cmpmos_g     <= 1'b1;
            cmnmos_g     <= 1'b0;
            busy         <= 1'b0;
            fault_sticky <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                state_q[l] <= state_d[l];
                cnt_q[l]   <= cnt_d[l];
            end
            opmos_g      <= pg_d[0];
            onmos_g      <= ng_d[0];
            cmpmos_g     <= pg_d[1];
            cmnmos_g     <= ng_d[1];
            busy         <= busy_d;
            fault_sticky <= fault_d;
        end
    end

endmodule

// File: tb/tb_digota_gate_drv.sv
// Directed bench for digota_gate_drv: latency, dead time, faults, reset.
// Expected output vectors are hand-derived per step.
module tb_digota_gate_drv;

    localparam int FILT_LEN = 3;
`ifdef DIGOTA_GLITCH_FILTER_EN
    localparam int LAT   = 3 + FILT_LEN;
    localparam int PULSE = FILT_LEN;
`else
    localparam int LAT   = 3;
    localparam int PULSE = 1;
`endif

    // Per-leg gate pairs {pmos_g, nmos_g}
    localparam logic [1:0] G_OFF = 2'b10;
    localparam logic [1:0] G_P   = 2'b00;
    localparam logic [1:0] G_N   = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       opmos_req, onmos_req, cmpmos_req, cmnmos_req;
    logic [3:0] dt_sel;
    logic       fault_clr;
    logic       opmos_g, onmos_g, cmpmos_g, cmnmos_g, busy, fault_sticky;

    int n_total = 0;
    int n_pass  = 0;

    digota_gate_drv #(.DT_W(4), .FILT_LEN(FILT_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opmos_req    (opmos_req),
        .onmos_req    (onmos_req),
        .cmpmos_req   (cmpmos_req),
        .cmnmos_req   (cmnmos_req),
        .dt_sel       (dt_sel),
        .fault_clr    (fault_clr),
        .opmos_g      (opmos_g),
        .onmos_g      (onmos_g),
        .cmpmos_g     (cmpmos_g),
        .cmnmos_g     (cmnmos_g),
        .busy         (busy),
        .fault_sticky (fault_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] o_exp,
                       input logic [1:0] c_exp, input logic b_exp,
                       input logic f_exp);
        logic [5:0] obs;
        logic [5:0] exp_v;
        obs   = {opmos_g, onmos_g, cmpmos_g, cmnmos_g, busy, fault_sticky};
        exp_v = {o_exp, c_exp, b_exp, f_exp};
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp_v);
    endtask

    task automatic set_out(input logic p, input logic n);
        opmos_req = p;
        onmos_req = n;
    endtask

    task automatic set_cm(input logic p, input logic n);
        cmpmos_req = p;
        cmnmos_req = n;
    endtask

    initial begin
        rst_n = 1'b0;
        set_out(1'b1, 1'b0);
        set_cm(1'b1, 1'b0);
        dt_sel    = 4'd4;
        fault_clr = 1'b0;
        tick(3);
        chk("reset", G_OFF, G_OFF, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle", G_OFF, G_OFF, 1'b0, 1'b0);

        // OFF -> N on output leg
        set_out(1'b1, 1'b1);
        tick(LAT - 1);
        chk("n_early", G_OFF, G_OFF, 1'b0, 1'b0);
        tick();
        chk("n_on", G_N, G_OFF, 1'b0, 1'b0);

        // N -> P with dt_sel=4
        set_out(1'b0, 1'b0);
        tick(LAT - 1);
        chk("np_early", G_N, G_OFF, 1'b0, 1'b0);
        tick();
        chk("np_dead0", G_OFF, G_OFF, 1'b1, 1'b0);
        tick(2);
        chk("np_dead2", G_OFF, G_OFF, 1'b1, 1'b0);
        tick();
        chk("np_dead3", G_OFF, G_OFF, 1'b1, 1'b0);
        tick();
        chk("p_on", G_P, G_OFF, 1'b0, 1'b0);

        // P -> N with dt_sel=0: single dead cycle
        dt_sel = 4'd0;
        set_out(1'b1, 1'b1);
        tick(LAT);
        chk("dt0_dead", G_OFF, G_OFF, 1'b1, 1'b0);
        tick();
        chk("dt0_n_on", G_N, G_OFF, 1'b0, 1'b0);

        // CM leg independent: P, then reversal with dt_sel changed mid-dead
        set_cm(1'b0, 1'b0);
        tick(LAT);
        chk("cm_p_on", G_N, G_P, 1'b0, 1'b0);
        dt_sel = 4'd2;
        set_cm(1'b1, 1'b1);
        tick(LAT);
        chk("cm_dead0", G_N, G_OFF, 1'b1, 1'b0);
        dt_sel = 4'd7;
        tick();
        chk("cm_dead1", G_N, G_OFF, 1'b1, 1'b0);
        tick();
        chk("cm_n_on", G_N, G_N, 1'b0, 1'b0);

        // Both legs to OFF through one dead cycle
        dt_sel = 4'd1;
        set_out(1'b1, 1'b0);
        set_cm(1'b1, 1'b0);
        tick(LAT);
        chk("off_dead", G_OFF, G_OFF, 1'b1, 1'b0);
        tick();
        chk("off_both", G_OFF, G_OFF, 1'b0, 1'b0);

        // Conflict pulse on output leg
        set_out(1'b0, 1'b1);
        tick(PULSE);
        set_out(1'b1, 1'b0);
        tick(LAT - 1 - PULSE);
        chk("cf_early", G_OFF, G_OFF, 1'b0, 1'b0);
        tick();
        chk("cf_set", G_OFF, G_OFF, 1'b0, 1'b1);
        tick(PULSE + 2);
        chk("cf_hold", G_OFF, G_OFF, 1'b0, 1'b1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("cf_clr", G_OFF, G_OFF, 1'b0, 1'b0);

        // Conflict on CM leg coinciding with fault_clr: set wins
        set_cm(1'b0, 1'b1);
        tick(PULSE);
        set_cm(1'b1, 1'b0);
        tick(LAT - 1 - PULSE);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("cf_setwin", G_OFF, G_OFF, 1'b0, 1'b1);
        tick(PULSE + 2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("cf_clr2", G_OFF, G_OFF, 1'b0, 1'b0);

        // Reset mid-dead with dt_sel=8
        dt_sel = 4'd8;
        set_out(1'b0, 1'b0);
        tick(LAT);
        chk("rd_p_on", G_P, G_OFF, 1'b0, 1'b0);
        set_out(1'b1, 1'b1);
        tick(LAT);
        chk("rd_dead", G_OFF, G_OFF, 1'b1, 1'b0);
        tick(2);
        chk("rd_dead2", G_OFF, G_OFF, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rd_reset", G_OFF, G_OFF, 1'b0, 1'b0);
        tick();
        chk("rd_reset2", G_OFF, G_OFF, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(LAT - 1);
        chk("rd_early", G_OFF, G_OFF, 1'b0, 1'b0);
        tick();
        chk("rd_n_on", G_N, G_OFF, 1'b0, 1'b0);

`ifdef DIGOTA_GLITCH_FILTER_EN
        // Short pulse swallowed, steady request passes after 3+FILT_LEN
        set_out(1'b1, 1'b0);
        tick(2);
        set_out(1'b1, 1'b1);
        tick(10);
        chk("gf_pulse", G_N, G_OFF, 1'b0, 1'b0);
        set_cm(1'b0, 1'b0);
        tick(5);
        chk("gf_early", G_N, G_OFF, 1'b0, 1'b0);
        tick();
        chk("gf_steady", G_N, G_P, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/digota_gate_drv.md
DIGOTA_GATE_DRV -- requirements
Module: digota_gate_drv

Interface
REQ-001 Parameter DT_W, default 4: width of the dead-time select input and the per-leg dead-time counter.
REQ-002 Parameter FILT_LEN, default 3: stable-sample count used by the glitch filter (REQ-030); legal range 2..15.
REQ-003 clk  input  1  single block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 opmos_req  input  1  output-leg PMOS request from DIGOTA, active-low (0 = PMOS on); asynchronous to clk.
REQ-006 onmos_req  input  1  output-leg NMOS request, active-high (1 = NMOS on); asynchronous.
REQ-007 cmpmos_req  input  1  common-mode-leg PMOS request, active-low; asynchronous.
REQ-008 cmnmos_req  input  1  common-mode-leg NMOS request, active-high; asynchronous.
REQ-009 dt_sel  input  DT_W  dead-time length in clk cycles; value 0 is treated as 1.
REQ-010 fault_clr  input  1  synchronous clear of fault_sticky.
REQ-011 opmos_g / cmpmos_g  output  1 each  registered PMOS gate drives, active-low.
REQ-012 onmos_g / cmnmos_g  output  1 each  registered NMOS gate drives, active-high.
REQ-013 busy  output  1  high while either leg is in DEAD.
REQ-014 fault_sticky  output  1  set on any request conflict; held until fault_clr or reset.

Function
REQ-015 Each of the four request inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Both legs (output leg: opmos/onmos; CM leg: cmpmos/cmnmos) SHALL run identical, independent state machines with states OFF, P_ON, N_ON, DEAD.
REQ-017 Per leg, the decoded request SHALL be: P = pmos_req==0 and nmos_req==0; N = nmos_req==1 and pmos_req==1; OFF = pmos_req==1 and nmos_req==0; CONFLICT = pmos_req==0 and nmos_req==1.
REQ-018 CONFLICT SHALL be treated as OFF and SHALL set fault_sticky on the following edge.
REQ-019 Gate decode SHALL be: OFF and DEAD give pmos_g=1, nmos_g=0; P_ON gives pmos_g=0, nmos_g=0; N_ON gives pmos_g=1, nmos_g=1. PMOS-on and NMOS-on SHALL never be driven together in any cycle.
REQ-020 OFF transitions SHALL be: to P_ON on request P, to N_ON on request N, otherwise remain in OFF.
REQ-021 P_ON or N_ON SHALL move to DEAD on any decoded request other than its own; the counter loads max(dt_sel,1) on entry.
REQ-022 DEAD SHALL decrement the counter each cycle; on the cycle the count reaches 0 the leg enters the then-current request state (P_ON, N_ON or OFF).
REQ-023 DEAD SHALL therefore last exactly max(dt_sel,1) cycles. dt_sel changes during DEAD SHALL NOT affect the running count, and request changes during DEAD SHALL NOT restart it.
REQ-024 A P to N reversal SHALL always pass through DEAD, with no direct P_ON to N_ON or N_ON to P_ON transition.
REQ-025 Latency from an input change to the gate change, without the filter, SHALL be 3 clk edges: 2 synchronizer edges plus 1 state/output edge.
REQ-026 If fault_clr and a new conflict occur in the same cycle, set SHALL win.
REQ-027 busy SHALL be the registered OR of (leg state == DEAD) across both legs.

Reset
REQ-028 While rst_n==0 at a clock edge, the following SHALL apply:
- both legs go to OFF;
- opmos_g=1, onmos_g=0, cmpmos_g=1, cmnmos_g=0;
- counters, synchronizer flops and filter state are cleared to the OFF-request encoding;
- busy=0 and fault_sticky=0.
REQ-029 Reset asserted during DEAD or during an on state SHALL force OFF on that edge, with no dead-time completion.

Configuration
REQ-030 With macro DIGOTA_GLITCH_FILTER_EN defined, each synchronized request SHALL update its filtered copy only after FILT_LEN consecutive identical samples.
- Added latency is FILT_LEN cycles, for a total of 3+FILT_LEN edges.
- Pulses shorter than FILT_LEN cycles SHALL be ignored.
REQ-031 Without DIGOTA_GLITCH_FILTER_EN, the filter SHALL be absent, the synchronizer output SHALL drive the FSM directly, and FILT_LEN SHALL be unused.

Verification
REQ-032 Reset, then set onmos_req=1 and opmos_req=1 at edge 0 -> onmos_g=1 at edge 3; opmos_g stays 1 throughout.
REQ-033 In N_ON with dt_sel=4, switch to P request -> onmos_g=0 at edge 3; opmos_g=0 at edge 7; busy high for exactly edges 3..6.
REQ-034 dt_sel=0 on a P to N reversal -> exactly 1 DEAD cycle with both gates off.
REQ-035 Drive opmos_req=0 and onmos_req=1 for 1 cycle -> leg goes to or stays OFF, fault_sticky=1 and holds; fault_clr pulse -> fault_sticky=0 on the next edge.
REQ-036 Assert rst_n=0 mid-DEAD with dt_sel=8 -> all outputs take reset values on that edge; busy=0.
REQ-037 With DIGOTA_GLITCH_FILTER_EN and FILT_LEN=3: a 2-cycle request pulse -> no gate change; a steady request -> gate change at edge 6.
